// File: rtl/debug_dump_tx_pkg.sv
// debug_dump_tx_pkg: shared encodings and constants for the debug dump transmitter
//   ST_*            FSM state encoding
//   SEC_*           frame section encoding (PC, register file, data memory)
//   BYTES_PER_WORD  UART bytes per dumped word with the default widths
//   max_int         helper used to size the shared word counter
package debug_dump_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LATCH,
      ST_SEND,
      ST_WAIT,
      ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      SEC_PC,
      SEC_REGS,
      SEC_MEM
   } sec_t;

   localparam int NB_DATA_DEF    = 32;
   localparam int N_DATA_DEF     = 8;
   localparam int BYTES_PER_WORD = NB_DATA_DEF / N_DATA_DEF;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/debug_dump_tx_serializer.sv
// word_byte_serializer: loads one word and hands it out one byte at a time, LSB first
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   i_clear      clear shift register and byte counter
//   i_load       capture i_word, byte counter back to 0
//   i_word       word to serialize
//   i_shift      advance to the next byte
//   o_byte       current byte (low bits of the shift register)
//   o_byte_idx   index of the current byte within the word
//   o_last_byte  current byte is the last one of the word
module word_byte_serializer
   import debug_dump_tx_pkg::*;
#(
   parameter  int NB_DATA     = NB_DATA_DEF,
   parameter  int N_DATA      = N_DATA_DEF,
   localparam int N_BYTES     = NB_DATA / N_DATA,
   localparam int NB_BYTE_IDX = (N_BYTES > 1) ? $clog2(N_BYTES) : 1
)(
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   i_clear,
   input  logic                   i_load,
   input  logic [NB_DATA-1:0]     i_word,
   input  logic                   i_shift,
   output logic [N_DATA-1:0]      o_byte,
   output logic [NB_BYTE_IDX-1:0] o_byte_idx,
   output logic                   o_last_byte
);

   logic [NB_DATA-1:0]     r_shift;
   logic [NB_BYTE_IDX-1:0] r_byte;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_shift <= '0;
         r_byte  <= '0;
      end else if (i_clear) begin
         r_shift <= '0;
         r_byte  <= '0;
      end else if (i_load) begin
         r_shift <= i_word;
         r_byte  <= '0;
      end else if (i_shift) begin
         r_shift <= r_shift >> N_DATA;
         r_byte  <= r_byte + NB_BYTE_IDX'(1);
      end
   end

   assign o_byte      = r_shift[N_DATA-1:0];
   assign o_byte_idx  = r_byte;
   assign o_last_byte = (r_byte == NB_BYTE_IDX'(N_BYTES - 1));

endmodule

// File: rtl/debug_dump_tx.sv
// debug_dump_tx: streams PC, register file and data memory to the UART TX, 4 bytes per word LSB first
//   clock         rising-edge clock
//   reset         asynchronous active-low reset
//   dump_start_i  start a dump (sampled only in IDLE)
//   pc_i          current PC, captured when the PC word is latched
//   reg_addr_o    register-file debug read address (word index while in REGS)
//   reg_data_i    register data, one cycle after reg_addr_o
//   mem_addr_o    data-memory debug read address (word index while in MEM)
//   mem_data_i    memory data, one cycle after mem_addr_o
//   tx_data_o     byte to the UART TX, stable from one SEND to the next
//   tx_start_o    one-cycle load pulse to the UART TX
//   tx_done_i     one-cycle byte-sent pulse from the UART TX
//   busy_o        high outside IDLE
//   dump_done_o   one-cycle pulse after the final byte is sent
module debug_dump_tx
   import debug_dump_tx_pkg::*;
#(
   parameter int NB_DATA     = 32,
   parameter int N_DATA      = 8,
   parameter int NB_PC       = 7,
   parameter int N_REGS      = 32,
   parameter int NB_REG_ADDR = 5,
   parameter int N_MEM_WORDS = 32,
   parameter int NB_MEM_ADDR = 5
)(
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   dump_start_i,
   input  logic [NB_PC-1:0]       pc_i,
   output logic [NB_REG_ADDR-1:0] reg_addr_o,
   input  logic [NB_DATA-1:0]     reg_data_i,
   output logic [NB_MEM_ADDR-1:0] mem_addr_o,
   input  logic [NB_DATA-1:0]     mem_data_i,
   output logic [N_DATA-1:0]      tx_data_o,
   output logic                   tx_start_o,
   input  logic                   tx_done_i,
   output logic                   busy_o,
   output logic                   dump_done_o
);

   localparam int N_WORDS_MAX = max_int(N_REGS, N_MEM_WORDS);
   localparam int NB_WORD     = (N_WORDS_MAX > 1) ? $clog2(N_WORDS_MAX) : 1;
   localparam int N_BYTES     = NB_DATA / N_DATA;
   localparam int NB_BYTE_IDX = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

   state_t               r_state;
   state_t               w_next;
   sec_t                 r_sec;
   logic [NB_WORD-1:0]   r_word;
   logic [N_DATA-1:0]    r_tx_hold;

   logic                   w_start;
   logic                   w_byte_done;
   logic                   w_word_done;
   logic                   w_last_in_sec;
   logic                   w_last_word;
   logic [NB_DATA-1:0]     w_word;
   logic [N_DATA-1:0]      w_ser_byte;
   logic [NB_BYTE_IDX-1:0] w_byte_idx;
   logic                   w_last_byte;

   assign w_start     = (r_state == ST_IDLE) && dump_start_i;
   assign w_byte_done = (r_state == ST_WAIT) && tx_done_i;
   assign w_word_done = w_byte_done && w_last_byte;

   assign w_last_in_sec = (r_sec == SEC_PC)   ? 1'b1 :
                          (r_sec == SEC_REGS) ? (r_word == NB_WORD'(N_REGS - 1)) :
                                                (r_word == NB_WORD'(N_MEM_WORDS - 1));
   assign w_last_word   = (r_sec == SEC_MEM) && w_last_in_sec;

   // PC is zero-extended to a full word so every section shares one serializer
   assign w_word = (r_sec == SEC_PC)   ? {{(NB_DATA-NB_PC){1'b0}}, pc_i} :
                   (r_sec == SEC_REGS) ? reg_data_i : mem_data_i;

   word_byte_serializer #(
      .NB_DATA (NB_DATA),
      .N_DATA  (N_DATA)
   ) u_ser (
      .clock       (clock),
      .reset       (reset),
      .i_clear     (w_start),
      .i_load      (r_state == ST_LATCH),
      .i_word      (w_word),
      .i_shift     (w_byte_done && !w_last_byte),
      .o_byte      (w_ser_byte),
      .o_byte_idx  (w_byte_idx),
      .o_last_byte (w_last_byte)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  w_next = dump_start_i ? ST_FETCH : ST_IDLE;
         ST_FETCH: w_next = ST_LATCH;
         ST_LATCH: w_next = ST_SEND;
         ST_SEND:  w_next = ST_WAIT;
         ST_WAIT:  w_next = !tx_done_i  ? ST_WAIT :
                            !w_last_byte ? ST_SEND :
                            w_last_word  ? ST_DONE : ST_FETCH;
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // Counters return to PC/0 after the last word so the address outputs idle at 0
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_sec  <= SEC_PC;
         r_word <= '0;
      end else if (w_start) begin
         r_sec  <= SEC_PC;
         r_word <= '0;
      end else if (w_word_done) begin
         if (w_last_word) begin
            r_sec  <= SEC_PC;
            r_word <= '0;
         end else if (w_last_in_sec) begin
            r_sec  <= (r_sec == SEC_PC) ? SEC_REGS : SEC_MEM;
            r_word <= '0;
         end else begin
            r_word <= r_word + NB_WORD'(1);
         end
      end
   end

   // The serializer advances while a byte is still owed to the UART, so the
   // last sent byte is held separately to keep tx_data_o stable between SENDs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         r_tx_hold <= '0;
      else if (r_state == ST_SEND)
         r_tx_hold <= w_ser_byte;
   end

   always_comb begin
      tx_start_o  = (r_state == ST_SEND);
      tx_data_o   = (r_state == ST_SEND) ? w_ser_byte : r_tx_hold;
      busy_o      = (r_state != ST_IDLE);
      dump_done_o = (r_state == ST_DONE);
      reg_addr_o  = (r_sec == SEC_REGS) ? NB_REG_ADDR'(r_word) : '0;
      mem_addr_o  = (r_sec == SEC_MEM)  ? NB_MEM_ADDR'(r_word) : '0;
   end

   logic w_unused;
   assign w_unused = ^w_byte_idx;

endmodule

// File: tb/tb_debug_dump_tx.sv
// tb_debug_dump_tx: self-checking bench with mock UART, mock memories and a frame reference model
module tb_debug_dump_tx;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        dump_start_i = 1'b0;
   logic [6:0]  pc_i = '0;
   logic [4:0]  reg_addr_o;
   logic [31:0] reg_data_i = '0;
   logic [4:0]  mem_addr_o;
   logic [31:0] mem_data_i = '0;
   logic [7:0]  tx_data_o;
   logic        tx_start_o;
   logic        tx_done_i = 1'b0;
   logic        busy_o;
   logic        dump_done_o;

   always #5 clock = ~clock;

   debug_dump_tx dut (
      .clock        (clock),
      .reset        (reset),
      .dump_start_i (dump_start_i),
      .pc_i         (pc_i),
      .reg_addr_o   (reg_addr_o),
      .reg_data_i   (reg_data_i),
      .mem_addr_o   (mem_addr_o),
      .mem_data_i   (mem_data_i),
      .tx_data_o    (tx_data_o),
      .tx_start_o   (tx_start_o),
      .tx_done_i    (tx_done_i),
      .busy_o       (busy_o),
      .dump_done_o  (dump_done_o)
   );

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   logic [31:0] regs [32];
   logic [31:0] mem  [32];
   logic [7:0]  got  [$];
   logic [7:0]  expq [$];
   int          start_cyc [$];
   int          done_cyc  [$];
   int          ndone = 0;
   int          done_at = 0;
   int          dly_cnt = 0;
   bit          same_mode = 1'b0;
   bit          rand_dly = 1'b0;
   bit          have_byte = 1'b0;
   logic [7:0]  last_byte = '0;
   logic [4:0]  pra = '0;
   logic [4:0]  pma = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: sample DUT at the falling edge, then drive mock UART and memories
   task automatic tick();
      @(negedge clock);
      cyc++;
      if (reset && busy_o && !tx_start_o && have_byte)
         check("tx_hold", {24'b0, tx_data_o}, {24'b0, last_byte});
      if (tx_start_o) begin
         got.push_back(tx_data_o);
         start_cyc.push_back(cyc);
         last_byte = tx_data_o;
         have_byte = 1'b1;
      end
      if (dump_done_o) begin
         ndone++;
         done_at = cyc;
      end
      if (!reset) begin
         dly_cnt   = 0;
         tx_done_i = 1'b0;
      end else if (tx_start_o) begin
         dly_cnt   = rand_dly ? int'($urandom_range(1, 12)) : 10;
         tx_done_i = same_mode;
      end else if (dly_cnt > 0) begin
         tx_done_i = (dly_cnt == 1);
         if (dly_cnt == 1) done_cyc.push_back(cyc);
         dly_cnt--;
      end else begin
         tx_done_i = 1'b0;
      end
      reg_data_i = regs[pra];
      mem_data_i = mem[pma];
      pra = reg_addr_o;
      pma = mem_addr_o;
   endtask

   task automatic clear_log();
      got.delete();
      start_cyc.delete();
      done_cyc.delete();
      ndone = 0;
      have_byte = 1'b0;
   endtask

   // Reference frame: PC word, 32 register words, 32 memory words, each LSB first
   task automatic build_exp(input logic [6:0] pc);
      logic [31:0] w;
      expq.delete();
      for (int k = 0; k < 65; k++) begin
         w = (k == 0) ? {25'b0, pc} : (k <= 32) ? regs[k-1] : mem[k-33];
         for (int b = 0; b < 4; b++) expq.push_back(8'((w >> (8 * b)) & 32'hFF));
      end
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (ndone == 0 && n < budget) begin
         tick();
         n++;
      end
      check("done_seen", {31'b0, ndone != 0}, 32'd1);
   endtask

   task automatic check_frame(input int c0);
      check("frame_len", got.size(), 32'd260);
      check("dump_done_cnt", ndone, 32'd1);
      if (start_cyc.size() > 0) check("first_start_lat", start_cyc[0] - c0, 32'd3);
      if (done_cyc.size() > 0) check("done_after_last", done_at - done_cyc[done_cyc.size()-1], 32'd1);
      for (int i = 0; i < got.size() && i < expq.size(); i++)
         check($sformatf("byte[%0d]", i), {24'b0, got[i]}, {24'b0, expq[i]});
      for (int k = 0; k + 1 < start_cyc.size() && k < done_cyc.size(); k++)
         check($sformatf("gap[%0d]", k), start_cyc[k+1] - done_cyc[k], (k % 4 == 3) ? 32'd3 : 32'd1);
   endtask

   initial begin
      int c0;
      int n0;
      int n;
      for (int i = 0; i < 32; i++) begin
         regs[i] = 32'h01010101 * i;
         mem[i]  = 32'hA0000000 + i;
      end
      regs[3] = 32'h80230000;

      // Reset held with a start request present
      reset = 1'b0;
      dump_start_i = 1'b1;
      repeat (3) tick();
      check("rst_tx_data", {24'b0, tx_data_o}, 32'd0);
      check("rst_tx_start", {31'b0, tx_start_o}, 32'd0);
      check("rst_busy", {31'b0, busy_o}, 32'd0);
      check("rst_dump_done", {31'b0, dump_done_o}, 32'd0);
      check("rst_reg_addr", {27'b0, reg_addr_o}, 32'd0);
      check("rst_mem_addr", {27'b0, mem_addr_o}, 32'd0);
      dump_start_i = 1'b0;
      reset = 1'b1;
      repeat (4) tick();
      check("idle_busy", {31'b0, busy_o}, 32'd0);
      check("idle_no_tx", got.size(), 32'd0);

      // Frame 1: directed contents, fixed UART latency, PC changed after start
      clear_log();
      pc_i = 7'h11;
      dump_start_i = 1'b1;
      c0 = cyc;
      tick();
      dump_start_i = 1'b0;
      pc_i = 7'h25;
      n = 0;
      while (got.size() < 100 && n < 3000) begin
         tick();
         n++;
      end
      dump_start_i = 1'b1;
      tick();
      dump_start_i = 1'b0;
      wait_done(5000);
      build_exp(7'h25);
      check_frame(c0);
      check("f1_b0", {24'b0, got[0]}, 32'h25);
      check("f1_b1", {24'b0, got[1]}, 32'h00);
      check("f1_b8", {24'b0, got[8]}, 32'h01);
      check("f1_b11", {24'b0, got[11]}, 32'h01);
      check("f1_b16", {24'b0, got[16]}, 32'h00);
      check("f1_b17", {24'b0, got[17]}, 32'h00);
      check("f1_b18", {24'b0, got[18]}, 32'h23);
      check("f1_b19", {24'b0, got[19]}, 32'h80);
      check("f1_b256", {24'b0, got[256]}, 32'h1F);
      check("f1_b259", {24'b0, got[259]}, 32'hA0);
      repeat (6) tick();
      check("f1_no_restart", got.size(), 32'd260);
      check("f1_idle", {31'b0, busy_o}, 32'd0);

      // Frame 2: random contents and latency, same-cycle tx_done, start held high
      for (int i = 0; i < 32; i++) begin
         regs[i] = $urandom;
         mem[i]  = $urandom;
      end
      pc_i = 7'($urandom);
      same_mode = 1'b1;
      rand_dly = 1'b1;
      clear_log();
      dump_start_i = 1'b1;
      c0 = cyc;
      tick();
      wait_done(5000);
      build_exp(pc_i);
      check_frame(c0);

      // Held start: next frame begins from IDLE right after DONE
      n = 0;
      while (got.size() <= 260 && n < 20) begin
         tick();
         n++;
      end
      dump_start_i = 1'b0;
      same_mode = 1'b0;
      rand_dly = 1'b0;
      if (start_cyc.size() > 260) check("restart_gap", start_cyc[260] - done_at, 32'd4);
      else check("restart_seen", start_cyc.size(), 32'd261);

      // Reset in the WAIT of byte 7 of the new frame
      n = 0;
      while (got.size() < 268 && n < 500) begin
         tick();
         n++;
      end
      check("f3_reached_b7", {31'b0, got.size() >= 268}, 32'd1);
      tick();
      reset = 1'b0;
      n0 = got.size();
      repeat (5) tick();
      check("midrst_busy", {31'b0, busy_o}, 32'd0);
      check("midrst_tx_start", {31'b0, tx_start_o}, 32'd0);
      check("midrst_no_bytes", got.size(), n0);
      reset = 1'b1;
      repeat (15) tick();
      check("midrst_still_idle", got.size(), n0);

      // Frame 4: restart after reset, random latency
      pc_i = 7'h25;
      rand_dly = 1'b1;
      clear_log();
      dump_start_i = 1'b1;
      c0 = cyc;
      tick();
      dump_start_i = 1'b0;
      wait_done(5000);
      build_exp(7'h25);
      check_frame(c0);
      check("f4_b0", {24'b0, got[0]}, 32'h25);
      check("f4_b3", {24'b0, got[3]}, 32'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/debug_dump_tx.md
Name: debug_dump_tx

Overview:
- Dumps processor state to the host over the UART TX byte interface after a run. It is the return path of the UART instruction loader, which receives bytes and assembles 32-bit words.
- Streams one frame: the PC, then every register-file word, then every data-memory word. Each word is split into 4 bytes, sent LSB first, matching the loader's byte order.
- Sits between the pipeline debug read ports and the UART TX.

Parameters:
- NB_DATA, 32, word width
- N_DATA, 8, UART byte width
- NB_PC, 7, PC width
- N_REGS, 32, register words dumped
- NB_REG_ADDR, 5, register address width
- N_MEM_WORDS, 32, data-memory words dumped
- NB_MEM_ADDR, 5, data-memory word-address width

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- dump_start_i  in  1  request a dump; sampled only in IDLE
- pc_i  in  NB_PC  current PC
- reg_addr_o  out  NB_REG_ADDR  register-file debug read address
- reg_data_i  in  NB_DATA  register data, valid 1 cycle after address
- mem_addr_o  out  NB_MEM_ADDR  data-memory debug read address
- mem_data_i  in  NB_DATA  memory data, valid 1 cycle after address
- tx_data_o  out  N_DATA  byte to the UART TX
- tx_start_o  out  1  1-cycle pulse: UART TX loads tx_data_o
- tx_done_i  in  1  1-cycle pulse from the UART TX: byte fully sent
- busy_o  out  1  high in any state other than IDLE
- dump_done_o  out  1  1-cycle pulse after the last byte's tx_done_i

Behaviour:
- Reset (reset=0, asynchronous): state IDLE.
  - All outputs are 0: tx_data_o, tx_start_o, busy_o, dump_done_o, reg_addr_o, mem_addr_o.
  - Section, word and byte counters are cleared.
  - Reset mid-byte aborts the frame; no further tx_start_o is issued.
- Sections, in order:
  - PC: 1 word, {zero-ext, pc_i}.
  - REGS: N_REGS words, index 0 up.
  - MEM: N_MEM_WORDS words, index 0 up.
  - Frame length = 4*(1+N_REGS+N_MEM_WORDS) bytes; 260 with defaults.
- Address outputs:
  - reg_addr_o = current word index while in REGS, else 0.
  - mem_addr_o = current word index while in MEM, else 0.
- FSM states: IDLE, FETCH, LATCH, SEND, WAIT, DONE.
  - IDLE: on dump_start_i=1 -> FETCH; section=PC, word=0, byte=0.
  - FETCH (1 cycle): address outputs are valid -> LATCH.
  - LATCH (1 cycle): the 32-bit shift register captures pc / reg_data_i / mem_data_i for the current section -> SEND.
  - SEND (1 cycle): tx_start_o=1; tx_data_o = shift[7:0] -> WAIT.
  - WAIT: hold until tx_done_i=1, then:
    - byte<3: shift >>= 8, byte++ -> SEND.
    - byte==3, more words in the frame: byte=0, advance word/section -> FETCH.
    - byte==3, last word of MEM -> DONE.
  - DONE (1 cycle): dump_done_o=1 -> IDLE.
- Timing: with dump_start_i sampled at cycle 0, the first tx_start_o is at cycle 3. Consecutive bytes of the same word: tx_start_o 1 cycle after tx_done_i. Next word: tx_start_o 3 cycles after tx_done_i.
- tx_data_o holds stable from SEND until the next SEND.
- tx_done_i is ignored outside WAIT, including in SEND.
- dump_start_i is ignored while busy. If held high through DONE, a new frame starts from IDLE on the next cycle.
- Section wrap: the word counter resets to 0 on each section change. Counters are sized to the larger of N_REGS and N_MEM_WORDS.
- pc_i is sampled in LATCH, not at dump_start_i.

Decomposition:
- Shared package:
  - FSM state encoding.
  - Section encoding (SEC_PC, SEC_REGS, SEC_MEM).
  - BYTES_PER_WORD = NB_DATA/N_DATA.
- Sub-module word_byte_serializer: 32-bit load/shift register plus byte counter, with outputs byte_o and last_byte_o. The FSM and section sequencing stay in the top.

Test Plan:
- Reset: hold reset=0 with dump_start_i=1 -> all outputs 0, busy_o=0; release -> dump begins only after dump_start_i is sampled in IDLE.
- Full frame: pc_i=7'h25, reg[i]=32'h01010101*i, mem[i]=32'hA0000000+i; mock UART returns tx_done_i 10 cycles after each tx_start_o.
  - Captured stream begins 25 00 00 00, 00 00 00 00, 01 01 01 01.
  - Ends 1F 00 00 A0.
  - Exactly 260 tx_start_o pulses; dump_done_o pulses once, 1 cycle after the final tx_done_i.
- Byte order: reg[3]=32'h80230000 -> bytes 00 00 23 80 at stream offsets 16..19.
- Cycle timing: first tx_start_o at cycle 3 after dump_start_i; mock UART asserts tx_done_i in the same cycle as tx_start_o -> ignored, bytes not advanced.
- Busy: dump_start_i pulsed mid-frame -> no restart, stream unchanged. dump_start_i held high -> second frame starts the cycle after dump_done_o.
- Reset mid-operation: reset=0 during WAIT of byte 7 -> tx_start_o stops, busy_o=0. A new dump_start_i -> the stream restarts at 25 00 00 00.
